fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
`timescale 1ns/1ps
// Round-robin packet arbiter for one FIFO write port; the owner holds the lock until its last beat or MAX_LEN beats.
// Grant costs one IDLE cycle, beats then pass combinationally (0 cycles); wfull holds the owner's beat, never the arbitration.
module fifo_write_arbiter #(
    parameter int NREQ    = 4,
    parameter int UWIDTH  = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*UWIDTH-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        ack,
    input  logic                   wfull,
    output logic                   winc,
    output logic [UWIDTH-1:0]      wdata,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   len_err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            r_state;
    logic [2:0]        r_grant_id;
    logic [2:0]        r_rr_ptr;
    logic [7:0]        r_beat_cnt;
    logic              r_len_err;

    logic              w_arb_found;
    logic [2:0]        w_arb_idx;
    logic              w_own_req;
    logic              w_own_last;
    logic [UWIDTH-1:0] w_own_data;
    logic              w_xfer;
    logic              w_end;
    logic [2:0]        w_next_ptr;

    // First requester at or above rr_ptr, wrapping; rr_ptr < NREQ so one subtraction wraps.
    always_comb begin
        int idx;
        idx         = 0;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!w_arb_found && req[i] && (idx == i)) begin
                    w_arb_found = 1'b1;
                    w_arb_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant_id == 3'(i)) begin
                w_own_req  = req[i];
                w_own_last = req_last[i];
                w_own_data = req_data[i*UWIDTH +: UWIDTH];
            end
        end
    end

    assign w_xfer     = (r_state == S_BURST) && w_own_req && !wfull;
    assign w_end      = w_xfer && (w_own_last || (r_beat_cnt == 8'(MAX_LEN - 1)));
    assign w_next_ptr = (r_grant_id == 3'(NREQ - 1)) ? 3'd0 : r_grant_id + 3'd1;

    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = w_xfer && (r_grant_id == 3'(i));
        end
    end

    assign winc     = w_xfer;
    assign wdata    = w_xfer ? w_own_data : '0;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == S_BURST);
    assign len_err  = r_len_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arb_found) begin
                        r_grant_id <= w_arb_idx;
                        r_beat_cnt <= '0;
                        r_state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (w_end) begin
                            r_state  <= S_IDLE;
                            r_rr_ptr <= w_next_ptr;
                            // Ending without last means the packet was cut at MAX_LEN.
                            if (!w_own_last) begin
                                r_len_err <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
`timescale 1ns/1ps
// Bench for fifo_write_arbiter: queue-fed requesters, a packet-level reference model, and directed scenarios.
module tb_fifo_write_arbiter;
    localparam int NREQ = 4;
    localparam int UW   = 8;
    localparam int MAXL = 16;
    localparam int DW   = NREQ * UW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [DW-1:0]   req_data = '0;
    logic [NREQ-1:0] req_last = '0;
    logic            wfull = 1'b0;
    logic [NREQ-1:0] ack;
    logic            winc;
    logic [UW-1:0]   wdata;
    logic [2:0]      grant_id;
    logic            busy;
    logic            len_err;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NREQ(NREQ), .UWIDTH(UW), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .wfull(wfull), .winc(winc), .wdata(wdata),
        .grant_id(grant_id), .busy(busy), .len_err(len_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic [NREQ-1:0] v, input int idx);
        logic [1:0] b;
        b = 2'(idx);
        return v[b];
    endfunction

    function automatic logic [UW-1:0] data_of(input int idx);
        logic [DW-1:0] t;
        t = req_data >> (idx * UW);
        return t[UW-1:0];
    endfunction

    // Requester sources: each entry is {last, data}; a beat leaves its queue once acked.
    logic [8:0]      srcq [NREQ][$];
    logic [NREQ-1:0] hold  = '0;
    logic [NREQ-1:0] ack_s = '0;

    always @(posedge clk) begin
        logic [NREQ-1:0] nr;
        logic [NREQ-1:0] nl;
        logic [DW-1:0]   nd;
        logic [8:0]      hd;
        #2;
        nr = '0;
        nl = '0;
        nd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rst && bit_of(ack_s, i) && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (srcq[i].size() > 0) begin
                hd = srcq[i][0];
                if (!bit_of(hold, i)) nr = nr | (NREQ'(1) << i);
                if (hd[8]) nl = nl | (NREQ'(1) << i);
                nd = nd | (DW'(hd[7:0]) << (i * UW));
            end
        end
        req      = nr;
        req_last = nl;
        req_data = nd;
    end

    // Packet-level reference: who owns the port, beats written in this packet, next search start.
    int   m_owner  = -1;
    int   m_ptr    = 0;
    int   m_cnt    = 0;
    logic m_lenerr = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner  = -1;
            m_ptr    = 0;
            m_cnt    = 0;
            m_lenerr = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && bit_of(req, (m_ptr + k) % NREQ)) begin
                    m_owner = (m_ptr + k) % NREQ;
                    m_cnt   = 0;
                end
            end
        end else if (bit_of(req, m_owner) && !wfull) begin
            m_cnt++;
            if (bit_of(req_last, m_owner) || m_cnt == MAXL) begin
                if (!bit_of(req_last, m_owner)) m_lenerr = 1'b1;
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
    end

    logic [UW-1:0] wr_q [$];
    logic [2:0]    gnt_q [$];
    logic          hist [$];
    logic          rec = 1'b0;
    logic          busy_q = 1'b0;
    int            ack2_cnt = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_ack;
        logic            e_winc;
        logic [UW-1:0]   e_wd;
        logic            e_busy;
        ack_s = ack;
        if (winc) wr_q.push_back(wdata);
        if (bit_of(ack, 2)) ack2_cnt++;
        if (busy && !busy_q) gnt_q.push_back(grant_id);
        busy_q = busy;
        if (rec) hist.push_back(winc);

        e_busy = rst && (m_owner >= 0);
        e_winc = e_busy && bit_of(req, m_owner) && !wfull;
        e_ack  = e_winc ? (NREQ'(1) << m_owner) : '0;
        e_wd   = e_winc ? data_of(m_owner) : '0;
        chk("m_busy",   32'(busy),    32'(e_busy));
        chk("m_winc",   32'(winc),    32'(e_winc));
        chk("m_ack",    32'(ack),     32'(e_ack));
        chk("m_wdata",  32'(wdata),   32'(e_wd));
        chk("m_lenerr", 32'(len_err), 32'(m_lenerr));
        if (e_busy) chk("m_grant", 32'(grant_id), 32'(m_owner));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_logs();
        wr_q.delete();
        gnt_q.delete();
        hist.delete();
        ack2_cnt = 0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        srcq[r].push_back({l, d});
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += srcq[i].size();
        return s;
    endfunction

    function automatic logic [31:0] gget(input int i);
        return (i < gnt_q.size()) ? 32'(gnt_q[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] wget(input int i);
        return (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hDEAD;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            smp();
            n++;
            done = (m_owner < 0) && (pending() == 0);
        end
        chk({name, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int   exp_g [8];
        int   ones;
        int   n;
        logic alt;

        // Reset state
        repeat (2) smp();
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_winc",   32'(winc),     32'd0);
        chk("rst_ack",    32'(ack),      32'd0);
        chk("rst_wdata",  32'(wdata),    32'd0);
        chk("rst_grant",  32'(grant_id), 32'd0);
        chk("rst_lenerr", 32'(len_err),  32'd0);

        // req=1010 after reset: grant 1, then 3
        step();
        rst = 1'b1;
        clr_logs();
        push(1, 8'h11, 1'b1);
        push(3, 8'h33, 1'b1);
        smp();
        chk("a_pre_busy", 32'(busy), 32'd0);
        step();
        smp();
        chk("a_busy",  32'(busy),     32'd1);
        chk("a_grant", 32'(grant_id), 32'd1);
        chk("a_ack",   32'(ack),      32'h2);
        chk("a_wdata", 32'(wdata),    32'h11);
        wait_idle("a", 20);
        chk("a_ngnt", 32'(gnt_q.size()), 32'd2);
        chk("a_g0", gget(0), 32'd1);
        chk("a_g1", gget(1), 32'd3);
        chk("a_w1", wget(1), 32'h33);

        // All four requesting single-beat packets: 0,1,2,3,0,... and winc every other cycle
        step();
        clr_logs();
        rec = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < NREQ; r++)
                push(r, 8'(8'h80 + r * 16 + p), 1'b1);
        wait_idle("c", 60);
        rec = 1'b0;
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8; i++) chk($sformatf("c_g%0d", i), gget(i), 32'(exp_g[i]));
        chk("c_w4", wget(4), 32'h81);
        ones = 0;
        alt  = 1'b1;
        for (int j = 0; j < 16 && j < hist.size(); j++) begin
            if (hist[j]) ones++;
            if (hist[j] !== 1'(j % 2)) alt = 1'b0;
        end
        chk("c_nsamp",    32'(hist.size()), 32'd17);
        chk("c_duty_ones", 32'(ones), 32'd8);
        chk("c_duty_alt",  32'(alt),  32'd1);

        // Requester 2, three beats, wfull on beat 2 and on the last beat
        step();
        clr_logs();
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b0);
        push(2, 8'hA3, 1'b1);
        step();
        step();
        wfull = 1'b1;
        smp();
        chk("b_full_winc", 32'(winc), 32'd0);
        chk("b_full_busy", 32'(busy), 32'd1);
        step();
        wfull = 1'b0;
        smp();
        chk("b_a2_winc",  32'(winc),  32'd1);
        chk("b_a2_wdata", 32'(wdata), 32'hA2);
        step();
        wfull = 1'b1;
        smp();
        chk("b_lastfull_busy", 32'(busy), 32'd1);
        chk("b_lastfull_winc", 32'(winc), 32'd0);
        step();
        wfull = 1'b0;
        smp();
        chk("b_a3_wdata", 32'(wdata), 32'hA3);
        wait_idle("b", 20);
        chk("b_nwr", 32'(wr_q.size()), 32'd3);
        chk("b_w0", wget(0), 32'hA1);
        chk("b_w1", wget(1), 32'hA2);
        chk("b_w2", wget(2), 32'hA3);
        chk("b_acks", 32'(ack2_cnt), 32'd3);

        // Requester 0, 20 beats without last: cut after 16
        step();
        clr_logs();
        for (int k = 0; k < 20; k++) push(0, 8'(8'h40 + k), 1'b0);
        n = 0;
        while (wr_q.size() < 16 && n < 100) begin
            smp();
            n++;
        end
        chk("d_16_seen",  32'(wr_q.size()), 32'd16);
        chk("d_pre_err",  32'(len_err),     32'd0);
        chk("d_pre_busy", 32'(busy),        32'd1);
        step();
        srcq[0].delete();
        smp();
        chk("d_busy",  32'(busy),        32'd0);
        chk("d_err",   32'(len_err),     32'd1);
        chk("d_nwr",   32'(wr_q.size()), 32'd16);
        chk("d_first", wget(0),          32'h40);
        chk("d_last",  wget(15),         32'h4F);
        repeat (3) smp();
        chk("d_err_sticky", 32'(len_err),     32'd1);
        chk("d_idle",       32'(busy),        32'd0);
        chk("d_nwr_after",  32'(wr_q.size()), 32'd16);

        // Owner 2 stalls five cycles while requester 1 waits
        step();
        clr_logs();
        push(2, 8'hE1, 1'b0);
        push(2, 8'hE2, 1'b0);
        push(2, 8'hE3, 1'b0);
        push(2, 8'hE4, 1'b1);
        step();
        step();
        hold = 4'b0100;
        push(1, 8'hD1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            smp();
            chk($sformatf("e_busy%0d", c),  32'(busy),     32'd1);
            chk($sformatf("e_ack%0d", c),   32'(ack),      32'd0);
            chk($sformatf("e_grant%0d", c), 32'(grant_id), 32'd2);
        end
        step();
        hold = '0;
        wait_idle("e", 30);
        chk("e_g0",  gget(0), 32'd2);
        chk("e_g1",  gget(1), 32'd1);
        chk("e_nwr", 32'(wr_q.size()), 32'd5);
        chk("e_w4",  wget(4), 32'hD1);

        // Reset on beat 2 of a 4-beat packet, then arbitration restarts at requester 0
        step();
        clr_logs();
        push(3, 8'hC1, 1'b0);
        push(3, 8'hC2, 1'b0);
        push(3, 8'hC3, 1'b0);
        push(3, 8'hC4, 1'b1);
        step();
        step();
        #2;
        chk("f_pre_winc",  32'(winc),  32'd1);
        chk("f_pre_wdata", 32'(wdata), 32'hC2);
        rst = 1'b0;
        #1;
        chk("f_ack",    32'(ack),      32'd0);
        chk("f_winc",   32'(winc),     32'd0);
        chk("f_wdata",  32'(wdata),    32'd0);
        chk("f_busy",   32'(busy),     32'd0);
        chk("f_grant",  32'(grant_id), 32'd0);
        chk("f_lenerr", 32'(len_err),  32'd0);
        for (int r = 0; r < NREQ; r++) srcq[r].delete();
        step();
        step();
        rst = 1'b1;
        clr_logs();
        push(1, 8'h71, 1'b1);
        push(3, 8'h73, 1'b1);
        step();
        smp();
        chk("f_new_busy",  32'(busy),     32'd1);
        chk("f_new_grant", 32'(grant_id), 32'd1);
        wait_idle("f", 20);
        chk("f_g1", gget(1), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
